// File: rtl/core_lsu.sv
// core_lsu: load/store unit between the core execution stage and data memory.
//
// Converts a core access request into a req/gnt/rvalid memory transaction,
// generates byte enables and lane-replicated store data, and sign/zero
// extends load data. Misaligned and illegal-size accesses complete with an
// error without touching memory.
//
// Handshake: the core raises req_i in a cycle where busy_o=0; the request is
// accepted on that clock edge. done_o pulses for one cycle when the access
// completes (err_o qualifies it), and a new req_i in that same cycle is
// accepted. Toward memory, mem_req_o and all request fields stay stable
// until the cycle mem_gnt_i=1; load data is taken on the first mem_rvalid_i
// after the grant. Grant/rvalid seen while idle are ignored.
//
// Optional feature: define LSU_TIMEOUT_EN to abort an access that has not
// completed TIMEOUT_CYCLES cycles after entering REQ (done_o+err_o, rdata_o=0).
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   req_i, we_i, size_i,           core request (size: 00 byte, 01 half,
//   unsigned_i, addr_i, wdata_i    10 word, 11 illegal)
//   busy_o, done_o, err_o, rdata_o core status / load result
//   mem_req_o, mem_we_o, mem_be_o, memory request side (registered)
//   mem_addr_o, mem_wdata_o
//   mem_gnt_i, mem_rvalid_i,       memory response side
//   mem_rdata_i
module core_lsu #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Fields of the accepted request needed for load extraction.
  logic       we_q;
  logic [1:0] size_q;
  logic       uns_q;
  logic [1:0] off_q;

  logic        bad_req;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] load_ext;
  logic        accept, reject, store_done, load_done, timeout_hit;

  // Address bits above the memory window are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[31:ADDR_WIDTH+2];

  assign busy_o = (state_q != S_IDLE);

  // Request decode.
  always_comb begin
    bad_req  = (size_i == 2'b11) ||
               (size_i == 2'b01 && addr_i[0]) ||
               (size_i == 2'b10 && addr_i[1:0] != 2'b00);
    be_in    = 4'b1111;
    wdata_in = wdata_i;
    case (size_i)
      2'b00: begin
        be_in    = 4'b0001 << addr_i[1:0];
        wdata_in = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_in    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and extension.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h00;
    case (off_q)
      2'd0: b = mem_rdata_i[7:0];
      2'd1: b = mem_rdata_i[15:8];
      2'd2: b = mem_rdata_i[23:16];
      default: b = mem_rdata_i[31:24];
    endcase
    h = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns_q ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_ext = mem_rdata_i;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // A completing cycle always wins over the abort.
  assign timeout_hit = (state_q != S_IDLE) &&
                       (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) &&
                       !(state_q == S_REQ && mem_gnt_i && we_q) &&
                       !(state_q == S_RESP && mem_rvalid_i);

  // Counts cycles spent in REQ+RESP; zero whenever idle, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE || state_d == S_IDLE) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    reject     = 1'b0;
    store_done = 1'b0;
    load_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (bad_req) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          if (we_q) begin
            store_done = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (mem_rvalid_i) begin
          load_done = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Registered outputs and captured request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= 32'h0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'h0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'h0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
    end else begin
      done_o    <= reject | store_done | load_done | timeout_hit;
      err_o     <= reject | timeout_hit;
      mem_req_o <= (state_d == S_REQ);
      if (load_done)        rdata_o <= load_ext;
      else if (timeout_hit) rdata_o <= 32'h0;
      if (accept) begin
        we_q        <= we_i;
        size_q      <= size_i;
        uns_q       <= unsigned_i;
        off_q       <= addr_i[1:0];
        mem_addr_o  <= addr_i[ADDR_WIDTH+1:2];
        mem_we_o    <= we_i;
        mem_be_o    <= be_in;
        mem_wdata_o <= wdata_in;
      end else if (state_d != S_REQ) begin
        mem_we_o    <= 1'b0;
        mem_be_o    <= 4'h0;
        mem_wdata_o <= 32'h0;
      end
    end
  end

endmodule
